// File: rtl/alu_muldiv_module.sv
// Execute-stage integer ALU with iterative RV32M multiply/divide.
// Base ops finish in one cycle. Multiply is shift-add and divide is restoring.
// A valid/ready handshake on each side stalls the pipeline while an op runs.
module alu_muldiv_module #(
  parameter int unsigned XLEN               = 32,
  parameter int unsigned OP_W               = 5,
  parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            alu_input_flush,
  input  logic            alu_input_valid,
  output logic            alu_input_ready,
  input  logic [OP_W-1:0] alu_input_op,
  input  logic [XLEN-1:0] alu_input_a,
  input  logic [XLEN-1:0] alu_input_b,
  output logic            alu_output_valid,
  input  logic            alu_output_ready,
  output logic [XLEN-1:0] alu_output_result,
  output logic            alu_output_busy
);

  localparam int unsigned SHW       = $clog2(XLEN);
  localparam int unsigned CNT_W     = $clog2(XLEN + 1);
  localparam int unsigned PW        = 2 * XLEN;
  localparam int unsigned MUL_STEPS = XLEN / MUL_BITS_PER_CYCLE;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [OP_W-1:0] OP_ADD    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB    = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR     = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR    = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLL    = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL    = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA    = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLT    = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTU   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(16);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(17);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(18);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(19);
  localparam logic [OP_W-1:0] OP_DIV    = OP_W'(20);
  localparam logic [OP_W-1:0] OP_DIVU   = OP_W'(21);
  localparam logic [OP_W-1:0] OP_REM    = OP_W'(22);
  localparam logic [OP_W-1:0] OP_REMU   = OP_W'(23);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  // Control state
  logic [1:0]      state_q, state_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Multiply datapath
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic            pneg_q, pneg_d;

  // Divide datapath
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic            ov_q, ov_d;

  // Combinational helpers
  logic            accept;
  logic            consume;
  logic [XLEN-1:0] base_res;
  logic            a_sgn, b_sgn, div_sgn;
  logic            is_mul, is_div;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [PW-1:0]   mul_acc_nx, mul_cand_t, mul_prod;
  logic [XLEN-1:0] mul_mp_t, mul_res;
  logic [XLEN:0]   rem_shift, div_diff;
  logic [XLEN-1:0] quo_nx, rem_nx, q_fin, r_fin, div_res;

  assign alu_input_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && alu_output_ready);
  assign accept            = alu_input_valid && alu_input_ready && !alu_input_flush;
  assign consume           = valid_q && alu_output_ready;
  assign alu_output_valid  = valid_q;
  assign alu_output_result = result_q;
  assign alu_output_busy   = busy_q;

  // Single-cycle base operations on the incoming operands
  always_comb begin
    base_res = '0;
    case (alu_input_op)
      OP_ADD:  base_res = alu_input_a + alu_input_b;
      OP_SUB:  base_res = alu_input_a - alu_input_b;
      OP_AND:  base_res = alu_input_a & alu_input_b;
      OP_OR:   base_res = alu_input_a | alu_input_b;
      OP_XOR:  base_res = alu_input_a ^ alu_input_b;
      OP_SLL:  base_res = alu_input_a << alu_input_b[SHW-1:0];
      OP_SRL:  base_res = alu_input_a >> alu_input_b[SHW-1:0];
      OP_SRA:  base_res = $unsigned($signed(alu_input_a) >>> alu_input_b[SHW-1:0]);
      OP_SLT:  base_res = ($signed(alu_input_a) < $signed(alu_input_b)) ? XLEN'(1) : '0;
      OP_SLTU: base_res = (alu_input_a < alu_input_b) ? XLEN'(1) : '0;
      default: base_res = '0;
    endcase
  end

  // Op classification and magnitude of operands for the iterative units
  always_comb begin
    is_mul  = (alu_input_op == OP_MUL) || (alu_input_op == OP_MULH) ||
              (alu_input_op == OP_MULHSU) || (alu_input_op == OP_MULHU);
    is_div  = (alu_input_op == OP_DIV) || (alu_input_op == OP_DIVU) ||
              (alu_input_op == OP_REM) || (alu_input_op == OP_REMU);
    div_sgn = (alu_input_op == OP_DIV) || (alu_input_op == OP_REM);
    a_sgn   = (alu_input_op == OP_MULH) || (alu_input_op == OP_MULHSU) || div_sgn;
    b_sgn   = (alu_input_op == OP_MULH) || div_sgn;
    abs_a   = (a_sgn && alu_input_a[XLEN-1]) ? -alu_input_a : alu_input_a;
    abs_b   = (b_sgn && alu_input_b[XLEN-1]) ? -alu_input_b : alu_input_b;
  end

  // One shift-add step, then sign correction and half select of the product
  always_comb begin
    mul_acc_nx = acc_q;
    mul_cand_t = mcand_q;
    mul_mp_t   = mplier_q;
    for (int j = 0; j < int'(MUL_BITS_PER_CYCLE); j++) begin
      if (mul_mp_t[0]) begin
        mul_acc_nx = mul_acc_nx + mul_cand_t;
      end
      mul_cand_t = mul_cand_t << 1;
      mul_mp_t   = mul_mp_t >> 1;
    end
    mul_prod = pneg_q ? -mul_acc_nx : mul_acc_nx;
    mul_res  = (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[PW-1:XLEN];
  end

  // One restoring-divide step, then special cases and sign correction
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    div_diff  = rem_shift - {1'b0, dvsr_q};
    if (!div_diff[XLEN]) begin
      rem_nx = div_diff[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nx = rem_shift[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b0};
    end
    if (dz_q) begin
      q_fin = '1;
      r_fin = a_q;
    end else if (ov_q) begin
      q_fin = a_q;
      r_fin = '0;
    end else begin
      q_fin = qneg_q ? -quo_nx : quo_nx;
      r_fin = rneg_q ? -rem_nx : rem_nx;
    end
    div_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? q_fin : r_fin;
  end

  // Next-state and datapath update; flush overrides everything
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    result_d = result_q;
    op_d     = op_q;
    a_d      = a_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    pneg_d   = pneg_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    ov_d     = ov_q;

    if (alu_input_flush) begin
      state_d  = S_IDLE;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      result_d = '0;
    end else begin
      case (state_q)
        S_MUL: begin
          acc_d    = mul_acc_nx;
          mcand_d  = mcand_q << MUL_BITS_PER_CYCLE;
          mplier_d = mplier_q >> MUL_BITS_PER_CYCLE;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            result_d = mul_res;
          end
        end
        S_DIV: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (!dz_q && !ov_q) begin
            quo_d = quo_nx;
            rem_d = rem_nx;
          end
          // Special cases finish on the first DIV cycle
          if (dz_q || ov_q || (cnt_q == CNT_W'(1))) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            result_d = div_res;
          end
        end
        S_DONE: begin
          if (consume) begin
            state_d  = S_IDLE;
            valid_d  = 1'b0;
            result_d = '0;
          end
        end
        default: ;
      endcase

      if (accept) begin
        op_d = alu_input_op;
        a_d  = alu_input_a;
        if (is_mul) begin
          state_d  = S_MUL;
          busy_d   = 1'b1;
          valid_d  = 1'b0;
          result_d = '0;
          mcand_d  = PW'(abs_a);
          mplier_d = abs_b;
          acc_d    = '0;
          pneg_d   = (a_sgn && alu_input_a[XLEN-1]) ^ (b_sgn && alu_input_b[XLEN-1]);
          cnt_d    = CNT_W'(MUL_STEPS);
        end else if (is_div) begin
          state_d  = S_DIV;
          busy_d   = 1'b1;
          valid_d  = 1'b0;
          result_d = '0;
          quo_d    = abs_a;
          dvsr_d   = abs_b;
          rem_d    = '0;
          dz_d     = (alu_input_b == '0);
          ov_d     = div_sgn && (alu_input_a == XMIN) && (alu_input_b == '1);
          qneg_d   = div_sgn && (alu_input_a[XLEN-1] ^ alu_input_b[XLEN-1]);
          rneg_d   = div_sgn && alu_input_a[XLEN-1];
          cnt_d    = CNT_W'(XLEN);
        end else begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          valid_d  = 1'b1;
          result_d = base_res;
        end
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      op_q     <= '0;
      a_q      <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      pneg_q   <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      op_q     <= op_d;
      a_q      <= a_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      pneg_q   <= pneg_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      ov_q     <= ov_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_module.sv
// Bench for alu_muldiv_module (XLEN=32): directed vectors with literal
// expectations plus a randomized stream checked cycle by cycle against a
// behavioural model of results and latencies.
module tb_alu_muldiv_module;

  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  SRA = 5'd7,  SLT = 5'd8, SLTU = 5'd9;
  localparam logic [4:0] MUL = 5'd16, MULH = 5'd17, MULHU = 5'd19;
  localparam logic [4:0] DIV = 5'd20, DIVU = 5'd21, REM = 5'd22, REMU = 5'd23;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Model state: what the outputs must be after each edge
  bit          m_valid   = 1'b0;
  logic [31:0] m_result  = '0;
  logic [31:0] m_pending = '0;
  int          m_rem     = 0;

  alu_muldiv_module dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .alu_input_flush   (flush),
    .alu_input_valid   (in_valid),
    .alu_input_ready   (in_ready),
    .alu_input_op      (op),
    .alu_input_a       (a),
    .alu_input_b       (b),
    .alu_output_valid  (out_valid),
    .alu_output_ready  (out_ready),
    .alu_output_result (result),
    .alu_output_busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an op, from plain integer arithmetic
  function automatic logic [31:0] ref_result(input logic [4:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy, uy;
    logic [63:0] p;
    int ix, iy;
    logic signed [31:0] sr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    uy = longint'(y);
    ix = $signed(x);
    iy = $signed(y);
    case (o)
      5'd0:  return x + y;
      5'd1:  return x - y;
      5'd2:  return x & y;
      5'd3:  return x | y;
      5'd4:  return x ^ y;
      5'd5:  return x << y[4:0];
      5'd6:  return x >> y[4:0];
      5'd7:  begin sr = $signed(x) >>> y[4:0]; return sr; end
      5'd8:  return (ix < iy) ? 32'd1 : 32'd0;
      5'd9:  return (x < y) ? 32'd1 : 32'd0;
      5'd16: begin p = sx * sy; return p[31:0]; end
      5'd17: begin p = sx * sy; return p[63:32]; end
      5'd18: begin p = sx * uy; return p[63:32]; end
      5'd19: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
      5'd20: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return ix / iy;
      end
      5'd21: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'd22: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return ix % iy;
      end
      5'd23: return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  // Cycles from accept edge to result valid
  function automatic int ref_latency(input logic [4:0] o, input logic [31:0] x,
                                     input logic [31:0] y);
    if (o >= 5'd16 && o <= 5'd19) return 33;
    if (o >= 5'd20 && o <= 5'd23) begin
      if (y == 0) return 2;
      if ((o == 5'd20 || o == 5'd22) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
      return 33;
    end
    return 1;
  endfunction

  function automatic bit model_ready();
    return (!m_valid && m_rem == 0) || (m_valid && out_ready);
  endfunction

  // Behavioural model advanced on each clock edge
  initial begin
    bit rdy;
    bit take;
    int lat;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n || flush) begin
        m_valid  = 1'b0;
        m_result = '0;
        m_rem    = 0;
      end else begin
        rdy  = model_ready();
        take = in_valid && rdy;
        if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) begin
            m_valid  = 1'b1;
            m_result = m_pending;
          end
        end else if (m_valid && out_ready) begin
          m_valid  = 1'b0;
          m_result = '0;
        end
        if (take) begin
          m_pending = ref_result(op, a, b);
          lat       = ref_latency(op, a, b);
          if (lat == 1) begin
            m_valid  = 1'b1;
            m_result = m_pending;
            m_rem    = 0;
          end else begin
            m_valid  = 1'b0;
            m_result = '0;
            m_rem    = lat - 1;
          end
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_result", result, m_result);
        check("busy", 32'(busy), 32'(m_rem > 0));
        check("in_ready", 32'(in_ready), 32'(model_ready()));
      end
    end
  end

  // Drive one op with the consumer ready; check result and latency literally
  task automatic run_op(input string name, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    bit got;
    @(posedge clk); #1;
    op = o; a = x; b = y; in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    check({name, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!got) return;
    lat = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check(name, result, exp);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] rnd_op();
    int r;
    r = $urandom_range(0, 19);
    if (r < 10) return 5'(r);
    if (r < 18) return 5'(r + 6);
    if (r == 18) return 5'd10;
    return 5'd31;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1 check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    run_op("add_wrap", ADD, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1);
    run_op("sub", SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1);
    run_op("slt", SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("sltu", SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("sra", SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
    run_op("unknown_op", 5'd12, 32'h1234, 32'h5678, 32'd0, 1);
    run_op("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mul", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("div", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu_zero", DIVU, 32'd1234, 32'd0, 32'hFFFF_FFFF, 2);
    run_op("remu_zero", REMU, 32'd5, 32'd0, 32'd5, 2);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

    // Backpressure: result held while consumer stalls
    @(posedge clk); #1;
    out_ready = 1'b0; op = ADD; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_result", result, 32'd7);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", result, 32'd7);
      check("bp_ready_low", 32'(in_ready), 32'd0);
    end
    // Consume and accept a new request in the same cycle
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; op = ADD; a = 32'd10; b = 32'd20;
    @(negedge clk);
    check("b2b_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_result", result, 32'd30);

    // Flush in the middle of a divide
    @(posedge clk); #1;
    op = DIV; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    run_op("div_after_flush", DIV, 32'd100, 32'd7, 32'd14, 33);

    // Reset in the middle of a multiply
    @(posedge clk); #1;
    op = MUL; a = 32'd9; b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_op("mul_after_reset", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);

    // Randomized traffic with backpressure and rare flushes
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = rnd_op();
      a         = rnd_operand();
      b         = rnd_operand();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_module.md
Name: alu_muldiv_module

Overview:
Parametrised, handshaked successor to the combinational integer ALU. It executes the full RV32I ALU op set plus the RV32M multiply/divide ops. Base ops complete in one cycle; multiply and divide run iteratively over several cycles. It sits in the execute stage and stalls the pipeline through a valid/ready handshake.

Parameters:
XLEN, 32, operand/result width in bits (supported: 8, 16, 32, 64)
OP_W, 5, opcode width
MUL_BITS_PER_CYCLE, 1, multiplier bits retired per iteration (must be 1, 2 or 4 and divide XLEN)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
alu_input_flush  input  1  abort in-flight op, discard result
alu_input_valid  input  1  request valid
alu_input_ready  output  1  block can accept request
alu_input_op  input  OP_W  operation code
alu_input_a  input  XLEN  operand A (rs1)
alu_input_b  input  XLEN  operand B (rs2/imm)
alu_output_valid  output  1  result valid
alu_output_ready  input  1  consumer accepts result
alu_output_result  output  XLEN  result
alu_output_busy  output  1  multi-cycle op in progress

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount is b[log2(XLEN)-1:0].
  - 8 SLT: signed compare. 9 SLTU: unsigned compare. Result is 1 or 0, zero-extended.
  - 16 MUL (low XLEN bits), 17 MULH (s×s), 18 MULHSU (s×u), 19 MULHU (u×u).
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code is accepted and returns 0 with latency 1.
- Handshake: a request is accepted on a clk edge with alu_input_valid && alu_input_ready. A result is consumed on an edge with alu_output_valid && alu_output_ready.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: on accept of a base op, register the result and go to DONE. On MUL* go to MUL; on DIV*/REM* go to DIV. Operands are latched at accept.
  - MUL: shift-add on absolute/unsigned operands for XLEN/MUL_BITS_PER_CYCLE cycles, then sign-correct the 2·XLEN product, select high or low half, go to DONE.
  - DIV: restoring divide, one quotient bit per cycle, XLEN cycles, then sign-correct and go to DONE.
  - DONE: alu_output_valid=1 and the result is held stable until consumed. On consume, go to IDLE, or accept a new request in the same cycle.
- alu_input_ready = (state==IDLE) || (state==DONE && alu_output_ready). Deasserted in MUL/DIV.
- alu_output_busy = state is MUL or DIV.
- Latency from accept edge to alu_output_valid high:
  - base ops: 1 cycle
  - MUL*: XLEN/MUL_BITS_PER_CYCLE + 1 cycles
  - DIV*/REM*: XLEN + 1 cycles
- Divide special cases, resolved in DIV state with latency fixed at 2 cycles:
  - divide by zero: quotient all-ones, remainder = a.
  - signed overflow (a = most negative, b = -1): quotient = a, remainder = 0.
- REM sign follows the dividend. DIV truncates toward zero.
- Flush: alu_input_flush=1 at an edge forces IDLE and clears alu_output_valid. Any acceptance in that same cycle is ignored. Flush has priority over all other events.
- Reset (async, reset_n low):
  - state=IDLE
  - alu_output_valid=0
  - alu_output_result=0
  - alu_output_busy=0
  - alu_input_ready=1 after release
  - internal accumulators cleared
- alu_output_result is 0 whenever alu_output_valid=0, and holds its value under backpressure.

Test Plan:
- ADD 0xFFFFFFFF+1 -> 0x00000000, valid 1 cycle after accept. SUB 0-1 -> 0xFFFFFFFF.
- SLT a=0xFFFFFFFF, b=1 -> 1. SLTU same operands -> 0. SRA 0x80000000 by b=0x24 (shamt 4) -> 0xF8000000.
- MULH 0x80000000×0x80000000 -> 0x40000000. MUL 7×-3 -> 0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. busy high for 32 cycles, valid at cycle 33.
- DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF. DIVU x/0 -> 0xFFFFFFFF, REMU 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
- Hold alu_output_ready=0 for 5 cycles after a result -> result stable, input_ready=0. Raise ready together with a new valid ADD -> back-to-back accept in the consume cycle.
- Assert flush mid-DIV (cycle 10), and separately pull reset_n low mid-MUL -> IDLE next edge (reset immediately), no output_valid, next request completes correctly.
